// File: rtl/pkg_rv_mem.sv
// Shared types and address constants for the rv_core memory responder.
package pkg_rv_mem;

  typedef enum logic [0:0] {
    RUN,
    SPLIT
  } st_t;

  // Core-local MMIO window (MTIME/MTIMECMP live here).
  localparam logic [31:0] MMIO_BASE = 32'hffff8000;
  localparam logic [31:0] MMIO_MASK = 32'hfffffff0;

  function automatic logic is_mmio(input logic [31:0] adr);
    return (adr & MMIO_MASK) == MMIO_BASE;
  endfunction

endpackage

// File: rtl/rv_spram16.sv
// 16-bit single-port RAM with synchronous read and two byte enables.
module rv_spram16 #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] adr,
  input  logic [1:0]    we,
  input  logic [15:0]   wd,
  output logic [15:0]   rd
);

  logic [15:0] mem [2**AW];

  // Read returns the old contents when written in the same cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we[0]) mem[adr][7:0]  <= wd[7:0];
      if (we[1]) mem[adr][15:8] <= wd[15:8];
      rd <= mem[adr];
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Instruction/data responder over two 16-bit banks; collisions cost one SPLIT cycle,
// with the data side always served first.
module rv_mem_arb
  import pkg_rv_mem::*;
#(
  parameter int unsigned AW   = 14,
  parameter int unsigned ROMW = 0
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [31:0] i_adr,
  input  logic        i_re,
  output logic [31:0] i_dr,
  output logic        i_rdy,
  input  logic [31:0] d_adr,
  input  logic        d_re,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_dw,
  output logic [31:0] d_dr,
  output logic        d_rdy,
  output logic        werr
);

  st_t st_q, st_d;

  logic [AW:0]   pend_adr_q, pend_adr_d;
  logic          fetch_q, fswap_q, drd_q, dmmio_q, werr_q;
  logic [31:0]   i_hold_q, d_hold_q;

  logic          d_mmio, d_acc, rom_hit;
  logic [AW-1:0] dw_adr;
  logic [AW:0]   f_adr;
  logic [AW-1:0] f_w, f_w1;
  logic          do_fetch, do_dread, rom_wr;
  logic          en;
  logic [AW-1:0] adr_l, adr_h;
  logic [1:0]    we_l, we_h;
  logic [15:0]   rd_l, rd_h;

  logic unused_adr;
  assign unused_adr = ^{i_adr[31:AW+2], i_adr[0]};

  assign d_mmio  = is_mmio(d_adr);
  assign d_acc   = (d_re | (|d_we)) & ~d_mmio;
  assign dw_adr  = d_adr[AW+1:2];
  assign rom_hit = 32'(dw_adr) < ROMW;

  // Fetch halfword address; odd halfwords take the low half from the next word.
  assign f_adr = (st_q == SPLIT) ? pend_adr_q : i_adr[AW+1:1];
  assign f_w   = f_adr[AW:1];
  assign f_w1  = f_w + AW'(1);

  always_comb begin
    st_d       = st_q;
    pend_adr_d = pend_adr_q;
    do_fetch   = 1'b0;
    do_dread   = 1'b0;
    rom_wr     = 1'b0;
    en         = 1'b0;
    adr_l      = dw_adr;
    adr_h      = dw_adr;
    we_l       = 2'b00;
    we_h       = 2'b00;
    if (st_q == SPLIT) begin
      st_d     = RUN;
      do_fetch = 1'b1;
    end else begin
      do_dread = d_re;
      if (d_acc) begin
        en     = 1'b1;
        we_l   = rom_hit ? 2'b00 : d_we[1:0];
        we_h   = rom_hit ? 2'b00 : d_we[3:2];
        rom_wr = rom_hit & (|d_we);
        if (i_re) begin
          st_d       = SPLIT;
          pend_adr_d = i_adr[AW+1:1];
        end
      end else if (i_re) begin
        do_fetch = 1'b1;
      end
    end
    if (do_fetch) begin
      en    = 1'b1;
      adr_h = f_w;
      adr_l = f_adr[0] ? f_w1 : f_w;
    end
  end

  rv_spram16 #(
    .AW(AW)
  ) u_bank_l (
    .clk(clk),
    .en (en & xreset),
    .adr(adr_l),
    .we (we_l),
    .wd (d_dw[15:0]),
    .rd (rd_l)
  );

  rv_spram16 #(
    .AW(AW)
  ) u_bank_h (
    .clk(clk),
    .en (en & xreset),
    .adr(adr_h),
    .we (we_h),
    .wd (d_dw[31:16]),
    .rd (rd_h)
  );

  // Bank outputs are shared, so each side falls back to its hold register.
  always_comb begin
    i_dr = i_hold_q;
    if (fetch_q) i_dr = fswap_q ? {rd_l, rd_h} : {rd_h, rd_l};
    d_dr = d_hold_q;
    if (drd_q) d_dr = dmmio_q ? 32'h0 : {rd_h, rd_l};
  end

  assign i_rdy = (st_q == RUN);
  assign d_rdy = 1'b1;
  assign werr  = werr_q;

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      st_q       <= RUN;
      pend_adr_q <= '0;
      fetch_q    <= 1'b0;
      fswap_q    <= 1'b0;
      drd_q      <= 1'b0;
      dmmio_q    <= 1'b0;
      i_hold_q   <= '0;
      d_hold_q   <= '0;
      werr_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      pend_adr_q <= pend_adr_d;
      fetch_q    <= do_fetch;
      if (do_fetch) fswap_q <= f_adr[0];
      drd_q      <= do_dread;
      if (do_dread) dmmio_q <= d_mmio;
      if (fetch_q) i_hold_q <= i_dr;
      if (drd_q) d_hold_q <= d_dr;
      werr_q     <= werr_q | rom_wr;
    end
  end

endmodule
